// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared widths, control-bundle layout and bubble constants for the ID/EX stage
package id_ex_stage_pkg;
   localparam int XLEN = 32;
   localparam int RAW = 5;
   localparam int CTRL_W = 12;
   localparam int REGWRITE_BIT = 0;
   localparam int ALUSRC_BIT = 1;
   localparam int MEMWRITE_BIT = 2;
   localparam int MEMREAD_BIT = 3;
   localparam int BRANCH_BIT = 4;
   localparam int JUMP_BIT = 5;
   localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;
   localparam logic [31:0] CNT_MAX = '1;
   function automatic logic [31:0] sat_inc(input logic [31:0] c);
      return c == CNT_MAX ? c : c + 32'd1;
   endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side inputs, writeback bypass, and registered execute-side outputs
interface id_ex_stage_if #(
   parameter int XLEN = id_ex_stage_pkg::XLEN,
   parameter int RAW = id_ex_stage_pkg::RAW,
   parameter int CTRL_W = id_ex_stage_pkg::CTRL_W
);
   logic d_valid;
   logic [XLEN-1:0] d_pc, d_imm;
   logic [RAW-1:0] d_rs1, d_rs2, d_rd;
   logic d_rs1_used, d_rs2_used;
   logic [CTRL_W-1:0] d_ctrl;
   logic [XLEN-1:0] rf_rd1, rf_rd2;
   logic wb_we;
   logic [RAW-1:0] wb_rd;
   logic [XLEN-1:0] wb_wd;
   logic flush;
   logic stall;
   logic e_valid;
   logic [XLEN-1:0] e_pc, e_imm, e_op1, e_op2;
   logic [RAW-1:0] e_rs1, e_rs2, e_rd;
   logic [CTRL_W-1:0] e_ctrl;
   logic [31:0] bubble_cnt;
   modport master (
      output d_valid, d_pc, d_imm, d_rs1, d_rs2, d_rd, d_rs1_used, d_rs2_used, d_ctrl,
             rf_rd1, rf_rd2, wb_we, wb_rd, wb_wd, flush,
      input  stall, e_valid, e_pc, e_imm, e_rs1, e_rs2, e_rd, e_ctrl, e_op1, e_op2, bubble_cnt
   );
   modport slave (
      input  d_valid, d_pc, d_imm, d_rs1, d_rs2, d_rd, d_rs1_used, d_rs2_used, d_ctrl,
             rf_rd1, rf_rd2, wb_we, wb_rd, wb_wd, flush,
      output stall, e_valid, e_pc, e_imm, e_rs1, e_rs2, e_rd, e_ctrl, e_op1, e_op2, bubble_cnt
   );
endinterface

// File: rtl/id_ex_stage_operand_bypass.sv
// operand_bypass: resolves one source operand; x0 reads as zero, same-cycle writeback wins over stale RF data
module operand_bypass #(
   parameter int XLEN = id_ex_stage_pkg::XLEN,
   parameter int RAW = id_ex_stage_pkg::RAW
) (
   input  logic [RAW-1:0]  rs,
   input  logic [XLEN-1:0] rf,
   input  logic            wb_we,
   input  logic [RAW-1:0]  wb_rd,
   input  logic [XLEN-1:0] wb_wd,
   output logic [XLEN-1:0] op
);
   assign op = rs == '0 ? '0 : (wb_we && wb_rd != '0 && wb_rd == rs) ? wb_wd : rf;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with writeback bypass,
// load-use stall detection and a saturating bubble counter
module id_ex_stage #(
   parameter int XLEN = id_ex_stage_pkg::XLEN,
   parameter int RAW = id_ex_stage_pkg::RAW,
   parameter int CTRL_W = id_ex_stage_pkg::CTRL_W,
   parameter int MEMREAD_BIT = id_ex_stage_pkg::MEMREAD_BIT
) (
   input logic clk,
   input logic rst,
   id_ex_stage_if.slave bus
);
   import id_ex_stage_pkg::*;
   logic [XLEN-1:0] op1, op2;
   logic hz, bump;
   logic [31:0] cnt;
   operand_bypass #(.XLEN(XLEN), .RAW(RAW)) u_bp1 (
      .rs(bus.d_rs1), .rf(bus.rf_rd1), .wb_we(bus.wb_we), .wb_rd(bus.wb_rd), .wb_wd(bus.wb_wd), .op(op1)
   );
   operand_bypass #(.XLEN(XLEN), .RAW(RAW)) u_bp2 (
      .rs(bus.d_rs2), .rf(bus.rf_rd2), .wb_we(bus.wb_we), .wb_rd(bus.wb_rd), .wb_wd(bus.wb_wd), .op(op2)
   );
   // hz self-clears after one bubble because the bubble drops e_valid
   assign hz = bus.d_valid && bus.e_valid && bus.e_ctrl[MEMREAD_BIT] && bus.e_rd != '0 &&
               ((bus.d_rs1_used && bus.d_rs1 == bus.e_rd) || (bus.d_rs2_used && bus.d_rs2 == bus.e_rd));
   assign bus.stall = hz && !bus.flush;
   assign bump = bus.d_valid && (bus.flush || hz);
   assign bus.bubble_cnt = cnt;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.e_valid <= 1'b0;
         bus.e_pc <= '0;
         bus.e_imm <= '0;
         bus.e_rs1 <= '0;
         bus.e_rs2 <= '0;
         bus.e_rd <= '0;
         bus.e_ctrl <= '0;
         bus.e_op1 <= '0;
         bus.e_op2 <= '0;
         cnt <= '0;
      end else begin
         if (bus.flush || hz) begin
            bus.e_valid <= 1'b0;
            bus.e_pc <= '0;
            bus.e_imm <= '0;
            bus.e_rs1 <= '0;
            bus.e_rs2 <= '0;
            bus.e_rd <= '0;
            bus.e_ctrl <= BUBBLE_CTRL;
            bus.e_op1 <= '0;
            bus.e_op2 <= '0;
         end else begin
            bus.e_valid <= bus.d_valid;
            bus.e_pc <= bus.d_pc;
            bus.e_imm <= bus.d_imm;
            bus.e_rs1 <= bus.d_rs1;
            bus.e_rs2 <= bus.d_rs2;
            bus.e_rd <= bus.d_rd;
            bus.e_ctrl <= bus.d_valid ? bus.d_ctrl : BUBBLE_CTRL;
            bus.e_op1 <= op1;
            bus.e_op2 <= op2;
         end
         if (bump) cnt <= sat_inc(cnt);
      end
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage; expected execute packets are queued when decode is driven
module tb_id_ex_stage;
   typedef struct packed {
      logic v;
      logic [31:0] pc, imm;
      logic [4:0] rs1, rs2, rd;
      logic [11:0] ctrl;
      logic [31:0] op1, op2;
   } ex_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int vectors = 0;
   int errs = 0;
   logic [31:0] exp_cnt = '0;
   ex_t q[$];
   ex_t exp_e;
   id_ex_stage_if bus ();
   id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   function automatic ex_t got();
      return {bus.e_valid, bus.e_pc, bus.e_imm, bus.e_rs1, bus.e_rs2, bus.e_rd, bus.e_ctrl, bus.e_op1, bus.e_op2};
   endfunction
   function automatic ex_t mk(logic v, logic [31:0] pc, logic [31:0] imm, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic [11:0] ctrl, logic [31:0] op1, logic [31:0] op2);
      return {v, pc, imm, rs1, rs2, rd, ctrl, op1, op2};
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic set_dec(input logic v, input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic u1, input logic u2,
                          input logic [11:0] ctrl, input logic [31:0] rf1, input logic [31:0] rf2);
      bus.d_valid = v;
      bus.d_pc = pc;
      bus.d_imm = imm;
      bus.d_rs1 = rs1;
      bus.d_rs2 = rs2;
      bus.d_rd = rd;
      bus.d_rs1_used = u1;
      bus.d_rs2_used = u2;
      bus.d_ctrl = ctrl;
      bus.rf_rd1 = rf1;
      bus.rf_rd2 = rf2;
   endtask
   task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] wd);
      bus.wb_we = we;
      bus.wb_rd = rd;
      bus.wb_wd = wd;
   endtask
   task automatic test_reset();
      set_dec(1, 32'hDEAD, 32'hBEEF, 3, 4, 5, 1, 1, 12'hFFF, 32'h1111, 32'h2222);
      set_wb(1, 3, 32'h77);
      bus.flush = 0;
      #12;
      vectors++;
      if (got() !== '0) begin errs++; $display("FAIL reset_e: got %h want 0", got()); end
      vectors++;
      if (bus.bubble_cnt !== 32'd0) begin errs++; $display("FAIL reset_cnt: got %h want 0", bus.bubble_cnt); end
      vectors++;
      if (bus.stall !== 1'b0) begin errs++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
      set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      set_wb(0, 0, 0);
      rst = 1;
   endtask
   task automatic test_capture();
      set_dec(1, 32'h100, 32'h7, 4, 6, 3, 1, 1, 12'h003, 14, 10);
      #1;
      vectors++;
      if (bus.stall !== 1'b0) begin errs++; $display("FAIL cap_stall: got %b want 0", bus.stall); end
      q.push_back(mk(1, 32'h100, 32'h7, 4, 6, 3, 12'h003, 14, 10));
      tick();
      exp_e = q.pop_front();
      vectors++;
      if (got() !== exp_e) begin errs++; $display("FAIL cap_e: got %h want %h", got(), exp_e); end
      set_dec(0, 32'h104, 32'h8, 1, 2, 7, 1, 1, 12'h0F3, 21, 22);
      q.push_back(mk(0, 32'h104, 32'h8, 1, 2, 7, 12'h000, 21, 22));
      tick();
      exp_e = q.pop_front();
      vectors++;
      if (got() !== exp_e) begin errs++; $display("FAIL cap_invalid: got %h want %h", got(), exp_e); end
   endtask
   task automatic test_bypass();
      set_dec(1, 32'h100, 32'h7, 4, 6, 3, 1, 1, 12'h003, 14, 10);
      set_wb(1, 4, 32'h55);
      q.push_back(mk(1, 32'h100, 32'h7, 4, 6, 3, 12'h003, 32'h55, 10));
      tick();
      exp_e = q.pop_front();
      vectors++;
      if (got() !== exp_e) begin errs++; $display("FAIL byp_rs1: got %h want %h", got(), exp_e); end
      set_wb(0, 4, 32'h55);
      q.push_back(mk(1, 32'h100, 32'h7, 4, 6, 3, 12'h003, 14, 10));
      tick();
      exp_e = q.pop_front();
      vectors++;
      if (got() !== exp_e) begin errs++; $display("FAIL byp_we0: got %h want %h", got(), exp_e); end
      set_dec(1, 32'h108, 32'h9, 0, 6, 3, 1, 1, 12'h003, 14, 10);
      set_wb(1, 0, 32'h55);
      q.push_back(mk(1, 32'h108, 32'h9, 0, 6, 3, 12'h003, 0, 10));
      tick();
      exp_e = q.pop_front();
      vectors++;
      if (got() !== exp_e) begin errs++; $display("FAIL byp_x0: got %h want %h", got(), exp_e); end
      set_wb(1, 6, 32'hA5A5);
      q.push_back(mk(1, 32'h108, 32'h9, 0, 6, 3, 12'h003, 0, 32'hA5A5));
      tick();
      exp_e = q.pop_front();
      vectors++;
      if (got() !== exp_e) begin errs++; $display("FAIL byp_rs2: got %h want %h", got(), exp_e); end
      set_wb(0, 0, 0);
   endtask
   task automatic test_load_use();
      set_dec(1, 32'h200, 32'h10, 2, 0, 9, 1, 0, 12'h009, 32'h30, 0);
      q.push_back(mk(1, 32'h200, 32'h10, 2, 0, 9, 12'h009, 32'h30, 0));
      tick();
      exp_e = q.pop_front();
      vectors++;
      if (got() !== exp_e) begin errs++; $display("FAIL lu_load: got %h want %h", got(), exp_e); end
      set_dec(1, 32'h204, 0, 3, 9, 5, 1, 1, 12'h001, 32'h33, 32'h99);
      #1;
      vectors++;
      if (bus.stall !== 1'b1) begin errs++; $display("FAIL lu_stall: got %b want 1", bus.stall); end
      q.push_back('0);
      exp_cnt = exp_cnt + 1;
      tick();
      exp_e = q.pop_front();
      vectors++;
      if (got() !== exp_e) begin errs++; $display("FAIL lu_bubble: got %h want %h", got(), exp_e); end
      vectors++;
      if (bus.bubble_cnt !== exp_cnt) begin errs++; $display("FAIL lu_cnt: got %h want %h", bus.bubble_cnt, exp_cnt); end
      vectors++;
      if (bus.stall !== 1'b0) begin errs++; $display("FAIL lu_unstall: got %b want 0", bus.stall); end
      q.push_back(mk(1, 32'h204, 0, 3, 9, 5, 12'h001, 32'h33, 32'h99));
      tick();
      exp_e = q.pop_front();
      vectors++;
      if (got() !== exp_e) begin errs++; $display("FAIL lu_replay: got %h want %h", got(), exp_e); end
   endtask
   task automatic test_flush();
      set_dec(1, 32'h220, 32'h4, 2, 0, 9, 1, 0, 12'h009, 32'h40, 0);
      q.push_back(mk(1, 32'h220, 32'h4, 2, 0, 9, 12'h009, 32'h40, 0));
      tick();
      exp_e = q.pop_front();
      vectors++;
      if (got() !== exp_e) begin errs++; $display("FAIL fl_load: got %h want %h", got(), exp_e); end
      set_dec(1, 32'h224, 0, 3, 9, 5, 1, 1, 12'h001, 32'h33, 32'h99);
      bus.flush = 1;
      #1;
      vectors++;
      if (bus.stall !== 1'b0) begin errs++; $display("FAIL fl_stall: got %b want 0", bus.stall); end
      q.push_back('0);
      exp_cnt = exp_cnt + 1;
      tick();
      exp_e = q.pop_front();
      vectors++;
      if (got() !== exp_e) begin errs++; $display("FAIL fl_bubble: got %h want %h", got(), exp_e); end
      vectors++;
      if (bus.bubble_cnt !== exp_cnt) begin errs++; $display("FAIL fl_cnt: got %h want %h", bus.bubble_cnt, exp_cnt); end
      set_dec(0, 32'h228, 0, 3, 9, 5, 1, 1, 12'h001, 1, 2);
      q.push_back('0);
      tick();
      exp_e = q.pop_front();
      vectors++;
      if (got() !== exp_e) begin errs++; $display("FAIL fl_idle: got %h want %h", got(), exp_e); end
      vectors++;
      if (bus.bubble_cnt !== exp_cnt) begin errs++; $display("FAIL fl_idle_cnt: got %h want %h", bus.bubble_cnt, exp_cnt); end
      bus.flush = 0;
      set_dec(1, 32'h300, 0, 1, 0, 0, 1, 0, 12'h008, 5, 0);
      q.push_back(mk(1, 32'h300, 0, 1, 0, 0, 12'h008, 5, 0));
      tick();
      exp_e = q.pop_front();
      vectors++;
      if (got() !== exp_e) begin errs++; $display("FAIL x0_load: got %h want %h", got(), exp_e); end
      set_dec(1, 32'h304, 0, 0, 0, 7, 1, 0, 12'h001, 32'h77, 0);
      #1;
      vectors++;
      if (bus.stall !== 1'b0) begin errs++; $display("FAIL x0_stall: got %b want 0", bus.stall); end
      set_dec(1, 32'h308, 0, 2, 0, 9, 1, 0, 12'h009, 6, 0);
      q.push_back(mk(1, 32'h308, 0, 2, 0, 9, 12'h009, 6, 0));
      tick();
      exp_e = q.pop_front();
      vectors++;
      if (got() !== exp_e) begin errs++; $display("FAIL unused_load: got %h want %h", got(), exp_e); end
      set_dec(1, 32'h30C, 0, 4, 9, 8, 1, 0, 12'h003, 32'h12, 32'h34);
      #1;
      vectors++;
      if (bus.stall !== 1'b0) begin errs++; $display("FAIL unused_stall: got %b want 0", bus.stall); end
      q.push_back(mk(1, 32'h30C, 0, 4, 9, 8, 12'h003, 32'h12, 32'h34));
      tick();
      exp_e = q.pop_front();
      vectors++;
      if (got() !== exp_e) begin errs++; $display("FAIL unused_cap: got %h want %h", got(), exp_e); end
   endtask
   task automatic test_saturate();
      force dut.cnt = 32'hFFFF_FFFE;
      #1;
      release dut.cnt;
      exp_cnt = 32'hFFFF_FFFE;
      set_dec(1, 32'h400, 0, 1, 2, 3, 1, 1, 12'h001, 1, 2);
      bus.flush = 1;
      for (int i = 0; i < 3; i++) begin
         q.push_back('0);
         exp_cnt = exp_cnt == 32'hFFFF_FFFF ? exp_cnt : exp_cnt + 1;
         tick();
         exp_e = q.pop_front();
         vectors++;
         if (got() !== exp_e) begin errs++; $display("FAIL sat_bubble%0d: got %h want %h", i, got(), exp_e); end
         vectors++;
         if (bus.bubble_cnt !== exp_cnt) begin errs++; $display("FAIL sat_cnt%0d: got %h want %h", i, bus.bubble_cnt, exp_cnt); end
      end
      bus.flush = 0;
   endtask
   task automatic test_async_reset();
      set_dec(1, 32'h500, 0, 2, 0, 9, 1, 0, 12'h009, 32'h50, 0);
      q.push_back(mk(1, 32'h500, 0, 2, 0, 9, 12'h009, 32'h50, 0));
      tick();
      exp_e = q.pop_front();
      vectors++;
      if (got() !== exp_e) begin errs++; $display("FAIL ar_load: got %h want %h", got(), exp_e); end
      set_dec(1, 32'h504, 0, 9, 0, 5, 1, 0, 12'h001, 1, 0);
      #1;
      vectors++;
      if (bus.stall !== 1'b1) begin errs++; $display("FAIL ar_stall: got %b want 1", bus.stall); end
      #2;
      rst = 0;
      #1;
      vectors++;
      if (got() !== '0) begin errs++; $display("FAIL ar_e: got %h want 0", got()); end
      vectors++;
      if (bus.bubble_cnt !== 32'd0) begin errs++; $display("FAIL ar_cnt: got %h want 0", bus.bubble_cnt); end
      vectors++;
      if (bus.stall !== 1'b0) begin errs++; $display("FAIL ar_stall_drop: got %b want 0", bus.stall); end
      set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      rst = 1;
      vectors++;
      if (q.size() != 0) begin errs++; $display("FAIL sb_leftover: got %0d want 0", q.size()); end
   endtask
   initial begin
      test_reset();
      test_capture();
      test_bypass();
      test_load_use();
      test_flush();
      test_saturate();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
